// File: rtl/col_merge.sv
// Column merge: per-column FIFOs feeding one round-robin arbitrated stream.
// Full FIFOs drop incoming beats and raise a sticky per-column overflow flag.
module col_merge #(
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COLS-1:0]            ival,
  input  logic [COLS-1:0][1:0]       idata,
  output logic                       mval,
  input  logic                       mrdy,
  output logic [1:0]                 mdata,
  output logic [$clog2(COLS)-1:0]    mcol,
  output logic [COLS-1:0]            ovf,
  input  logic [COLS-1:0]            ovf_clr,
  output logic [COLS-1:0]            fifo_empty
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  logic [1:0]    r_mem [COLS][DEPTH];
  logic [PW-1:0] r_wp  [COLS];
  logic [PW-1:0] r_rp  [COLS];
  logic [NW-1:0] r_cnt [COLS];
  logic [COLS-1:0] r_ovf;
  logic [COLS-1:0] r_empty;

  logic          r_mval;
  logic [1:0]    r_mdata;
  logic [CW-1:0] r_mcol;
  logic [CW-1:0] r_last;

  logic [COLS-1:0] w_ne;
  logic [COLS-1:0] w_pop;
  logic [COLS-1:0] w_push;
  logic [COLS-1:0] w_drop;
  logic [NW-1:0]   w_cnt_nxt [COLS];
  logic            w_load_ok;
  logic            w_gnt_v;
  logic [CW-1:0]   w_gnt;
  logic [1:0]      w_head;

  assign w_load_ok = !r_mval || mrdy;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      w_ne[c] = (r_cnt[c] != '0);
    end
  end

  // Scan last+1, last+2, ... so the previous winner has lowest priority
  always_comb begin
    w_gnt_v = 1'b0;
    w_gnt   = r_last;
    for (int i = 1; i <= COLS; i++) begin
      if (!w_gnt_v && w_ne[(int'(r_last) + i) % COLS]) begin
        w_gnt_v = 1'b1;
        w_gnt   = CW'((int'(r_last) + i) % COLS);
      end
    end
  end

  assign w_head = r_mem[w_gnt][r_rp[w_gnt]];

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      w_pop[c]  = w_load_ok && w_gnt_v && (w_gnt == CW'(c));
      w_drop[c] = ival[c] && (r_cnt[c] == FULL) && !w_pop[c];
      w_push[c] = ival[c] && !w_drop[c];
      w_cnt_nxt[c] = r_cnt[c];
      if (w_push[c] && !w_pop[c]) begin
        w_cnt_nxt[c] = r_cnt[c] + 1'b1;
      end else if (w_pop[c] && !w_push[c]) begin
        w_cnt_nxt[c] = r_cnt[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
      end
      r_ovf   <= '0;
      r_empty <= '1;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (w_push[c]) begin
          r_mem[c][r_wp[c]] <= idata[c];
          r_wp[c] <= r_wp[c] + 1'b1;
        end
        if (w_pop[c]) begin
          r_rp[c] <= r_rp[c] + 1'b1;
        end
        r_cnt[c]   <= w_cnt_nxt[c];
        r_empty[c] <= (w_cnt_nxt[c] == '0);
        // A drop in the same cycle as a clear keeps the flag set
        if (w_drop[c]) begin
          r_ovf[c] <= 1'b1;
        end else if (ovf_clr[c]) begin
          r_ovf[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mval  <= 1'b0;
      r_mdata <= '0;
      r_mcol  <= '0;
      r_last  <= CW'(COLS - 1);
    end else if (w_load_ok) begin
      if (w_gnt_v) begin
        r_mval  <= 1'b1;
        r_mdata <= w_head;
        r_mcol  <= w_gnt;
        r_last  <= w_gnt;
      end else begin
        r_mval  <= 1'b0;
      end
    end
  end

  assign mval       = r_mval;
  assign mdata      = r_mdata;
  assign mcol       = r_mcol;
  assign ovf        = r_ovf;
  assign fifo_empty = r_empty;

endmodule

// File: tb/tb_col_merge.sv
// Directed bench for col_merge: ordering, drops, backpressure,
// round-robin fairness, full push+pop and mid-run reset.
module tb_col_merge;

  logic            clk;
  logic            rst;
  logic [3:0]      ival;
  logic [3:0][1:0] idata;
  logic            mval;
  logic            mrdy;
  logic [1:0]      mdata;
  logic [1:0]      mcol;
  logic [3:0]      ovf;
  logic [3:0]      ovf_clr;
  logic [3:0]      fifo_empty;

  int n_tests;
  int n_fail;

  col_merge #(.COLS(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ival       (ival),
    .idata      (idata),
    .mval       (mval),
    .mrdy       (mrdy),
    .mdata      (mdata),
    .mcol       (mcol),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .fifo_empty (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input int c, input int d);
    chk({tag, " mval"}, int'(mval), 1);
    chk({tag, " mcol"}, int'(mcol), c);
    chk({tag, " mdata"}, int'(mdata), d);
  endtask

  int ecol [8];
  int edat [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    ival    = '0;
    idata   = '0;
    mrdy    = 1'b1;
    ovf_clr = '0;
    tick();
    tick();
    chk("rst mval", int'(mval), 0);
    chk("rst mdata", int'(mdata), 0);
    chk("rst mcol", int'(mcol), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst empty", int'(fifo_empty), 15);
    rst = 1'b0;
    tick();
    chk("rel mval", int'(mval), 0);

    // all four columns at once
    ival  = 4'b1111;
    idata = {2'd3, 2'd2, 2'd1, 2'd0};
    tick();
    ival = '0;
    chk("t1 n+1 mval", int'(mval), 0);
    chk("t1 n+1 empty", int'(fifo_empty), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      beat("t1 out", i, i);
    end
    tick();
    chk("t1 n+6 mval", int'(mval), 0);
    chk("t1 n+6 empty", int'(fifo_empty), 15);

    // column 2 overflow with output stalled
    mrdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ival     = 4'b0100;
      idata[2] = 2'(k % 4);
      tick();
    end
    ival = '0;
    chk("t2 ovf", int'(ovf), 4);
    beat("t2 head", 2, 0);
    ival     = 4'b0100;
    idata[2] = 2'd2;
    ovf_clr  = 4'b0100;
    tick();
    ival    = '0;
    ovf_clr = '0;
    chk("t2 set wins", int'(ovf), 4);
    mrdy = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      beat("t2 drain", 2, j % 4);
    end
    tick();
    chk("t2 end mval", int'(mval), 0);
    chk("t2 ovf held", int'(ovf), 4);
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = '0;
    chk("t2 ovf clr", int'(ovf), 0);

    // backpressure hold on column 1
    mrdy     = 1'b0;
    ival     = 4'b0010;
    idata[1] = 2'd2;
    tick();
    idata[1] = 2'd3;
    tick();
    ival = '0;
    beat("t3 load", 1, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("t3 hold", 1, 2);
    end
    mrdy = 1'b1;
    tick();
    beat("t3 next", 1, 3);
    tick();
    chk("t3 end mval", int'(mval), 0);

    // fairness between columns 0 and 3, from reset priority
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ecol = '{0, 3, 0, 3, 0, 3, 0, 3};
    edat = '{0, 3, 1, 2, 2, 1, 3, 0};
    for (int t = 1; t <= 10; t++) begin
      if (t <= 4) begin
        ival     = 4'b1001;
        idata[0] = 2'(t - 1);
        idata[3] = 2'(4 - t);
      end else begin
        ival = '0;
      end
      tick();
      if (t >= 2 && t <= 9) begin
        beat("t4 rr", ecol[t-2], edat[t-2]);
      end
      if (t == 10) begin
        chk("t4 end mval", int'(mval), 0);
      end
    end
    chk("t4 ovf", int'(ovf), 0);

    // column 1 full, push while popping
    mrdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ival     = 4'b0010;
      idata[1] = 2'(k % 4);
      tick();
    end
    beat("t5 head", 1, 0);
    mrdy = 1'b1;
    for (int k = 5; k < 8; k++) begin
      ival     = 4'b0010;
      idata[1] = 2'(k % 4);
      tick();
      beat("t5 pp", 1, (k - 4) % 4);
      chk("t5 ovf", int'(ovf), 0);
    end
    ival = '0;
    for (int j = 4; j < 8; j++) begin
      tick();
      beat("t5 drain", 1, j % 4);
    end
    tick();
    chk("t5 end mval", int'(mval), 0);

    // reset with queued column-0 beats and stalled output
    mrdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ival     = 4'b0001;
      idata[0] = 2'd3;
      tick();
    end
    ival = '0;
    beat("t6 pre", 0, 3);
    chk("t6 pre empty", int'(fifo_empty), 14);
    rst = 1'b1;
    tick();
    chk("t6 rst mval", int'(mval), 0);
    chk("t6 rst empty", int'(fifo_empty), 15);
    chk("t6 rst ovf", int'(ovf), 0);
    rst = 1'b0;
    tick();
    chk("t6 rel mval", int'(mval), 0);
    mrdy     = 1'b1;
    ival     = 4'b0011;
    idata[0] = 2'd1;
    idata[1] = 2'd2;
    tick();
    ival = '0;
    chk("t6 n+1 mval", int'(mval), 0);
    tick();
    beat("t6 first", 0, 1);
    tick();
    beat("t6 second", 1, 2);
    tick();
    chk("t6 end mval", int'(mval), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
